conn_table_searcher: RTL and testbench



---
 rtl/conn_table_searcher.sv | 248 ++++++++++++++++++++++++
 tb/tb_conn_table_searcher.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/conn_table_searcher.sv
// Connection-table engine: lookup-or-insert, lookup-only and delete-by-ID over a pipelined linear scan.
// Optional occupancy counter and output port enabled by defining RS_OCCUPANCY_EN.
module conn_table_searcher #(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned MAC_W  = 24,
  parameter int unsigned IP_W   = 32,
  parameter int unsigned PORT_W = 16,
  parameter int unsigned ID_W   = $clog2(DEPTH)
) (
  input  logic              rs_clk,
  input  logic              rs_rst_n,
  input  logic [1:0]        rs_rq,
  input  logic [ID_W-1:0]   rs_id_in,
  input  logic [MAC_W-1:0]  rs_mac_src,
  input  logic [MAC_W-1:0]  rs_mac_dst,
  input  logic [IP_W-1:0]   rs_ip_src,
  input  logic [IP_W-1:0]   rs_ip_dst,
  input  logic [PORT_W-1:0] rs_port_src,
  input  logic [PORT_W-1:0] rs_port_dst,
  output logic              rs_busy,
  output logic              rs_done,
  output logic [ID_W-1:0]   rs_id_out,
`ifdef RS_OCCUPANCY_EN
  output logic [ID_W:0]     rs_occupancy,
`endif
  output logic [7:0]        rs_error
);

  localparam int unsigned KEY_W = 2 * (MAC_W + IP_W + PORT_W);

  localparam logic [1:0] OP_INSERT = 2'b01;
  localparam logic [1:0] OP_DELETE = 2'b10;
  localparam logic [1:0] OP_LOOKUP = 2'b11;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SCAN  = 3'd1;
  localparam logic [2:0] ST_DRAIN = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic [7:0] ERR_INSERTED  = 8'h00;
  localparam logic [7:0] ERR_FOUND     = 8'h01;
  localparam logic [7:0] ERR_FULL      = 8'h02;
  localparam logic [7:0] ERR_NOT_FOUND = 8'h03;
  localparam logic [7:0] ERR_DEL_BAD   = 8'h04;
  localparam logic [7:0] ERR_DEL_OK    = 8'h05;

  localparam logic [ID_W-1:0] LAST_ADDR = ID_W'(DEPTH - 1);

  logic [2:0]       state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [ID_W-1:0]  del_id_q, del_id_d;
  logic [ID_W-1:0]  addr_q, addr_d;
  logic             cmp_vld_q, cmp_vld_d;
  logic [ID_W-1:0]  cmp_addr_q, cmp_addr_d;
  logic             free_found_q, free_found_d;
  logic [ID_W-1:0]  free_q, free_d;
  logic [ID_W-1:0]  res_id_q, res_id_d;
  logic [7:0]       res_err_q, res_err_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [ID_W-1:0]  id_out_q, id_out_d;
  logic [7:0]       err_out_q, err_out_d;
  logic [ID_W:0]    occ_q, occ_d;

  logic [KEY_W-1:0] mem [DEPTH];
  logic [KEY_W-1:0] rd_data_q;

  logic hit_c;
  logic free_hit_c;
  logic full_c;
  logic del_ok_c;
  logic we_c;

  // Compare stage works on the entry read one cycle earlier.
  assign hit_c      = cmp_vld_q && valid_q[cmp_addr_q] && (rd_data_q == key_q);
  assign free_hit_c = cmp_vld_q && !valid_q[cmp_addr_q] && !free_found_q;
  assign del_ok_c   = (32'(del_id_q) < DEPTH) && valid_q[del_id_q];

`ifdef RS_OCCUPANCY_EN
  assign full_c       = (occ_q == (ID_W + 1)'(DEPTH));
  assign rs_occupancy = occ_q;
`else
  assign full_c = 1'b0;
`endif

  assign rs_busy   = busy_q;
  assign rs_done   = done_q;
  assign rs_id_out = id_out_q;
  assign rs_error  = err_out_q;

  // Next-state and datapath control.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    key_d        = key_q;
    del_id_d     = del_id_q;
    addr_d       = addr_q;
    cmp_vld_d    = 1'b0;
    cmp_addr_d   = addr_q;
    free_found_d = free_found_q;
    free_d       = free_q;
    res_id_d     = res_id_q;
    res_err_d    = res_err_q;
    valid_d      = valid_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    id_out_d     = id_out_q;
    err_out_d    = err_out_q;
    occ_d        = occ_q;
    we_c         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // busy_q is still set here only during the rs_done cycle
        busy_d = 1'b0;
        if (!busy_q && (rs_rq != 2'b00)) begin
          state_d      = ST_SCAN;
          op_d         = rs_rq;
          key_d        = {rs_mac_src, rs_mac_dst, rs_ip_src, rs_ip_dst, rs_port_src, rs_port_dst};
          del_id_d     = rs_id_in;
          addr_d       = '0;
          free_found_d = 1'b0;
          free_d       = '0;
          busy_d       = 1'b1;
        end
      end

      ST_SCAN: begin
        if (op_q == OP_DELETE) begin
          state_d = ST_DONE;
          if (del_ok_c) begin
            valid_d[del_id_q] = 1'b0;
            res_id_d          = del_id_q;
            res_err_d         = ERR_DEL_OK;
            occ_d             = occ_q - (ID_W + 1)'(1);
          end else begin
            res_id_d  = '0;
            res_err_d = ERR_DEL_BAD;
          end
        end else if (hit_c) begin
          state_d   = ST_DONE;
          res_id_d  = cmp_addr_q;
          res_err_d = ERR_FOUND;
        end else begin
          if (free_hit_c) begin
            free_found_d = 1'b1;
            free_d       = cmp_addr_q;
          end
          cmp_vld_d = 1'b1;
          if (addr_q == LAST_ADDR) begin
            state_d = ST_DRAIN;
          end else begin
            addr_d = addr_q + ID_W'(1);
          end
        end
      end

      ST_DRAIN: begin
        state_d = ST_DONE;
        if (hit_c) begin
          res_id_d  = cmp_addr_q;
          res_err_d = ERR_FOUND;
        end else if (op_q == OP_LOOKUP) begin
          res_id_d  = '0;
          res_err_d = ERR_NOT_FOUND;
        end else if ((free_found_q || free_hit_c) && !full_c) begin
          state_d   = ST_WRITE;
          res_id_d  = free_found_q ? free_q : cmp_addr_q;
          res_err_d = ERR_INSERTED;
        end else begin
          res_id_d  = '0;
          res_err_d = ERR_FULL;
        end
      end

      ST_WRITE: begin
        we_c              = 1'b1;
        valid_d[res_id_q] = 1'b1;
        occ_d             = occ_q + (ID_W + 1)'(1);
        state_d           = ST_DONE;
      end

      ST_DONE: begin
        done_d    = 1'b1;
        id_out_d  = res_id_q;
        err_out_d = res_err_q;
        state_d   = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge rs_clk or negedge rs_rst_n) begin
    if (!rs_rst_n) begin
      state_q      <= ST_IDLE;
      op_q         <= 2'b00;
      key_q        <= '0;
      del_id_q     <= '0;
      addr_q       <= '0;
      cmp_vld_q    <= 1'b0;
      cmp_addr_q   <= '0;
      free_found_q <= 1'b0;
      free_q       <= '0;
      res_id_q     <= '0;
      res_err_q    <= 8'h00;
      valid_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      id_out_q     <= '0;
      err_out_q    <= 8'h00;
      occ_q        <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      key_q        <= key_d;
      del_id_q     <= del_id_d;
      addr_q       <= addr_d;
      cmp_vld_q    <= cmp_vld_d;
      cmp_addr_q   <= cmp_addr_d;
      free_found_q <= free_found_d;
      free_q       <= free_d;
      res_id_q     <= res_id_d;
      res_err_q    <= res_err_d;
      valid_q      <= valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      id_out_q     <= id_out_d;
      err_out_q    <= err_out_d;
      occ_q        <= occ_d;
    end
  end

  // Key RAM: synchronous read, single write port, contents not reset.
  always_ff @(posedge rs_clk) begin
    if (we_c) begin
      mem[res_id_q] <= key_q;
    end
    rd_data_q <= mem[addr_q];
  end

endmodule

// File: tb/tb_conn_table_searcher.sv
// Directed bench for conn_table_searcher at DEPTH=4: insert, lookup, delete, full table, busy and reset abort.
module tb_conn_table_searcher;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned MAC_W  = 24;
  localparam int unsigned IP_W   = 32;
  localparam int unsigned PORT_W = 16;
  localparam int unsigned ID_W   = $clog2(DEPTH);

  logic              rs_clk;
  logic              rs_rst_n;
  logic [1:0]        rs_rq;
  logic [ID_W-1:0]   rs_id_in;
  logic [MAC_W-1:0]  rs_mac_src;
  logic [MAC_W-1:0]  rs_mac_dst;
  logic [IP_W-1:0]   rs_ip_src;
  logic [IP_W-1:0]   rs_ip_dst;
  logic [PORT_W-1:0] rs_port_src;
  logic [PORT_W-1:0] rs_port_dst;
  logic              rs_busy;
  logic              rs_done;
  logic [ID_W-1:0]   rs_id_out;
  logic [7:0]        rs_error;
`ifdef RS_OCCUPANCY_EN
  logic [ID_W:0]     rs_occupancy;
`endif

  int n_checks = 0;
  int n_errors = 0;

  conn_table_searcher #(
    .DEPTH (DEPTH),
    .MAC_W (MAC_W),
    .IP_W  (IP_W),
    .PORT_W(PORT_W)
  ) dut (
    .rs_clk      (rs_clk),
    .rs_rst_n    (rs_rst_n),
    .rs_rq       (rs_rq),
    .rs_id_in    (rs_id_in),
    .rs_mac_src  (rs_mac_src),
    .rs_mac_dst  (rs_mac_dst),
    .rs_ip_src   (rs_ip_src),
    .rs_ip_dst   (rs_ip_dst),
    .rs_port_src (rs_port_src),
    .rs_port_dst (rs_port_dst),
    .rs_busy     (rs_busy),
    .rs_done     (rs_done),
    .rs_id_out   (rs_id_out),
`ifdef RS_OCCUPANCY_EN
    .rs_occupancy(rs_occupancy),
`endif
    .rs_error    (rs_error)
  );

  initial rs_clk = 1'b0;
  always #5 rs_clk = ~rs_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Keys differ in every field so a partial compare would still be caught.
  task automatic set_key(input int n);
    rs_mac_src  = MAC_W'(32'h00A000 + n);
    rs_mac_dst  = MAC_W'(32'h00B000 + n * 3);
    rs_ip_src   = IP_W'(32'hC0A80000 + n);
    rs_ip_dst   = IP_W'(32'h0A000000 + n * 7);
    rs_port_src = PORT_W'(1000 + n);
    rs_port_dst = PORT_W'(80 + n * 2);
  endtask

  // Issue one request, wait for rs_done within a cycle budget, check latency, id, code and busy.
  task automatic do_req(input string tag, input logic [1:0] op, input int key, input int id,
                        input bit corrupt, input int exp_lat, input int exp_id, input int exp_err);
    int lat;
    bit got;
    bit busy_ok;
    set_key(key);
    rs_id_in = ID_W'(id);
    rs_rq    = op;
    @(posedge rs_clk); #1;
    rs_rq = 2'b00;
    if (corrupt) rs_ip_src = ~rs_ip_src;
    lat = 0; got = 1'b0; busy_ok = 1'b1;
    while (lat < 100 && !got) begin
      if (!rs_busy) busy_ok = 1'b0;
      @(posedge rs_clk); #1;
      lat++;
      if (rs_done) got = 1'b1;
    end
    chk({tag, "/done"}, 32'(got), 32'd1);
    chk({tag, "/lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "/id"}, 32'(rs_id_out), 32'(exp_id));
    chk({tag, "/err"}, 32'(rs_error), 32'(exp_err));
    chk({tag, "/busy"}, 32'(busy_ok), 32'd1);
    @(posedge rs_clk); #1;
    chk({tag, "/idle"}, 32'(rs_busy), 32'd0);
  endtask

  initial begin
    int n_done;
    rs_rst_n = 1'b0;
    rs_rq    = 2'b00;
    rs_id_in = '0;
    set_key(0);
    repeat (3) @(posedge rs_clk);
    #1;
    chk("rst/busy", 32'(rs_busy), 32'd0);
    chk("rst/done", 32'(rs_done), 32'd0);
    chk("rst/id", 32'(rs_id_out), 32'd0);
    chk("rst/err", 32'(rs_error), 32'd0);
    @(negedge rs_clk);
    rs_rst_n = 1'b1;
    @(posedge rs_clk); #1;

    // Basic insert then lookup
    do_req("insA", 2'b01, 1, 0, 1'b0, 7, 0, 8'h00);
    do_req("lkA", 2'b11, 1, 0, 1'b0, 3, 0, 8'h01);

    // More inserts; input change after acceptance must not leak into C
    do_req("insB", 2'b01, 2, 0, 1'b0, 7, 1, 8'h00);
    do_req("insC", 2'b01, 3, 0, 1'b1, 7, 2, 8'h00);
    do_req("lkC", 2'b11, 3, 0, 1'b0, 5, 2, 8'h01);
    do_req("insA2", 2'b01, 1, 0, 1'b0, 3, 0, 8'h01);

    // Deletes and slot reuse; id 7 truncates to 3, which is empty
    do_req("del1", 2'b10, 0, 1, 1'b0, 2, 1, 8'h05);
    do_req("del1b", 2'b10, 0, 1, 1'b0, 2, 0, 8'h04);
    do_req("del7", 2'b10, 0, 7, 1'b0, 2, 0, 8'h04);
    do_req("lkB", 2'b11, 2, 0, 1'b0, 6, 0, 8'h03);
    do_req("insD", 2'b01, 4, 0, 1'b0, 7, 1, 8'h00);

    // Fill the table and overflow it
    do_req("insE", 2'b01, 5, 0, 1'b0, 7, 3, 8'h00);
`ifdef RS_OCCUPANCY_EN
    chk("occ/full", 32'(rs_occupancy), 32'd4);
`endif
    do_req("insF", 2'b01, 6, 0, 1'b0, 6, 0, 8'h02);
`ifdef RS_OCCUPANCY_EN
    chk("occ/after", 32'(rs_occupancy), 32'd4);
`endif
    do_req("fullA", 2'b11, 1, 0, 1'b0, 3, 0, 8'h01);
    do_req("fullD", 2'b11, 4, 0, 1'b0, 4, 1, 8'h01);
    do_req("fullC", 2'b11, 3, 0, 1'b0, 5, 2, 8'h01);
    do_req("fullE", 2'b11, 5, 0, 1'b0, 6, 3, 8'h01);

    // Requests while busy are ignored
    set_key(5);
    rs_rq = 2'b11;
    @(posedge rs_clk); #1;
    set_key(7);
    rs_rq  = 2'b01;
    n_done = 0;
    for (int i = 1; i <= 14; i++) begin
      if (i == 4) rs_rq = 2'b00;
      @(posedge rs_clk); #1;
      if (rs_done) begin
        n_done++;
        chk("busy/id", 32'(rs_id_out), 32'd3);
        chk("busy/err", 32'(rs_error), 32'h01);
      end
    end
    chk("busy/ndone", 32'(n_done), 32'd1);
    do_req("lkG", 2'b11, 7, 0, 1'b0, 6, 0, 8'h03);

    // Reset in the middle of an insert scan
    do_req("delC", 2'b10, 0, 2, 1'b0, 2, 2, 8'h05);
    set_key(8);
    rs_rq = 2'b01;
    @(posedge rs_clk); #1;
    rs_rq = 2'b00;
    repeat (2) @(posedge rs_clk);
    #1;
    chk("abort/pre", 32'(rs_busy), 32'd1);
    rs_rst_n = 1'b0;
    #1;
    chk("abort/busy", 32'(rs_busy), 32'd0);
    chk("abort/done", 32'(rs_done), 32'd0);
    n_done = 0;
    repeat (8) begin
      @(posedge rs_clk); #1;
      if (rs_done) n_done++;
    end
    @(negedge rs_rst_n or negedge rs_clk);
    rs_rst_n = 1'b1;
    repeat (8) begin
      @(posedge rs_clk); #1;
      if (rs_done) n_done++;
    end
    chk("abort/ndone", 32'(n_done), 32'd0);
`ifdef RS_OCCUPANCY_EN
    chk("occ/rst", 32'(rs_occupancy), 32'd0);
`endif
    do_req("rstH", 2'b11, 8, 0, 1'b0, 6, 0, 8'h03);
    do_req("rstA", 2'b11, 1, 0, 1'b0, 6, 0, 8'h03);
    do_req("rstE", 2'b11, 5, 0, 1'b0, 6, 0, 8'h03);
    do_req("rstIns", 2'b01, 5, 0, 1'b0, 7, 0, 8'h00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
